// File: rtl/serial_frame_ctrl_pkg.sv
// serial_frame_ctrl_pkg: shared state encoding and default sizing for the serial frame receiver
package serial_frame_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/serial_frame_ctrl_if.sv
// serial_frame_ctrl_if: link pins in, frame results out
interface serial_frame_ctrl_if import serial_frame_ctrl_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic i_in;
  logic s_in;
  logic [DATA_W-1:0] data_out;
  logic valid;
  logic err_parity;
  logic err_sync;
  logic [CNT_W-1:0] err_cnt;
  logic busy;
  modport master (output i_in, s_in, input data_out, valid, err_parity, err_sync, err_cnt, busy);
  modport slave (input i_in, s_in, output data_out, valid, err_parity, err_sync, err_cnt, busy);
endinterface

// File: rtl/serial_frame_ctrl_bit_timer.sv
// serial_frame_ctrl_bit_timer: mid-bit sample tick generator, half-period load then full-period reloads
module serial_frame_ctrl_bit_timer import serial_frame_ctrl_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic load_half,
  input  logic run,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  assign tick = run & (cnt == '0);
  // count down while running; the first tick lands mid-bit, later ones one bit period apart
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load_half) cnt <= CW'(CLKS_PER_BIT / 2);
    else if (tick) cnt <= CW'(CLKS_PER_BIT - 1);
    else if (run) cnt <= cnt - 1'b1;
endmodule

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: receive-side controller for the two-wire I/S serial link
module serial_frame_ctrl import serial_frame_ctrl_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic reset,
  serial_frame_ctrl_if.slave bus
);
  localparam int IW = $clog2(DATA_W);
  state_t state, state_n;
  logic [1:0] i_sync, s_sync;
  logic s_d, i_s, s_s, s_rise, tick, perr, valid_n, sync_n;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] shreg;
  assign i_s = i_sync[1];
  assign s_s = s_sync[1];
  assign s_rise = s_s & ~s_d;
  assign perr = ^{shreg, i_s} ^ (PARITY_ODD != 0);
  assign bus.busy = state != ST_IDLE;
  serial_frame_ctrl_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .reset(reset),
    .load_half((state == ST_IDLE) & s_rise),
    .run(state != ST_IDLE),
    .tick(tick)
  );
  // two-flop synchronizers on the asynchronous link lines, plus S history for edge detect
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      i_sync <= '0;
      s_sync <= '0;
      s_d <= 1'b0;
    end else begin
      i_sync <= {i_sync[0], bus.i_in};
      s_sync <= {s_sync[0], bus.s_in};
      s_d <= s_s;
    end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_n;
  // next state; S high at a data/parity tick restarts the frame as if it were a start sample
  always_comb begin
    state_n = state;
    sync_n = tick & s_s & ((state == ST_DATA) | (state == ST_PARITY));
    valid_n = tick & ~s_s & (state == ST_PARITY);
    unique case (state)
      ST_IDLE: state_n = s_rise ? ST_START : ST_IDLE;
      ST_START: state_n = tick ? (s_s ? ST_DATA : ST_IDLE) : ST_START;
      ST_DATA: state_n = (tick & ~s_s & (idx == '0)) ? ST_PARITY : ST_DATA;
      ST_PARITY: state_n = tick ? (s_s ? ST_DATA : ST_IDLE) : ST_PARITY;
      default: state_n = ST_IDLE;
    endcase
  end
  // shift register, bit index, frame results and saturating error counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx <= '0;
      shreg <= '0;
      bus.data_out <= '0;
      bus.valid <= 1'b0;
      bus.err_parity <= 1'b0;
      bus.err_sync <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      bus.valid <= valid_n;
      bus.err_sync <= sync_n;
      if (tick & s_s & (state != ST_IDLE)) idx <= IW'(DATA_W - 1);
      else if (tick & (state == ST_DATA)) begin
        shreg <= {shreg[DATA_W-2:0], i_s};
        idx <= idx - 1'b1;
      end
      if (valid_n) begin
        bus.data_out <= shreg;
        bus.err_parity <= perr;
      end
      if (((valid_n & perr) | sync_n) & ~&bus.err_cnt) bus.err_cnt <= bus.err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb_serial_frame_ctrl: directed frames with a scoreboard of expected frame reports
module tb_serial_frame_ctrl;
  typedef struct packed {
    logic [7:0] data;
    logic perr;
    logic [7:0] cnt;
  } frame_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_line = 1'b0;
  logic s_line = 1'b0;
  int checks = 0;
  int failures = 0;
  int sync_cnt = 0;
  int model_cnt = 0;
  frame_t exp_q[$];
  frame_t obs_q[$];
  serial_frame_ctrl_if #(.DATA_W(8), .CNT_W(8)) bus ();
  serial_frame_ctrl_if #(.DATA_W(8), .CNT_W(2)) bus2 ();
  assign bus.i_in = i_line;
  assign bus.s_in = s_line;
  assign bus2.i_in = i_line;
  assign bus2.s_in = s_line;
  serial_frame_ctrl #(.DATA_W(8), .CLKS_PER_BIT(10), .PARITY_ODD(0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  serial_frame_ctrl #(.DATA_W(8), .CLKS_PER_BIT(10), .PARITY_ODD(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (bus.valid === 1'b1) obs_q.push_back(frame_t'{bus.data_out, bus.err_parity, bus.err_cnt});
    if (bus.err_sync === 1'b1) sync_cnt++;
  endtask

  task automatic send_bit(input logic s, input logic i);
    s_line = s;
    i_line = i;
    repeat (10) cyc();
  endtask

  task automatic send_data(input logic [7:0] d, input logic par);
    for (int k = 7; k >= 0; k--) send_bit(1'b0, d[k]);
    send_bit(1'b0, par);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic par);
    logic perr;
    perr = ^d ^ par;
    if (perr && model_cnt < 255) model_cnt++;
    exp_q.push_back(frame_t'{d, perr, 8'(model_cnt)});
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par);
    expect_frame(d, par);
    send_bit(1'b1, 1'b0);
    send_data(d, par);
    send_bit(1'b0, 1'b0);
  endtask

  task automatic score(input string tag);
    frame_t e, o;
    for (int n = 0; n < 40 && obs_q.size() == 0; n++) cyc();
    check({tag, "_seen"}, 32'(obs_q.size()), 32'd1);
    e = exp_q.pop_front();
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check({tag, "_data"}, 32'(o.data), 32'(e.data));
      check({tag, "_perr"}, 32'(o.perr), 32'(e.perr));
      check({tag, "_cnt"}, 32'(o.cnt), 32'(e.cnt));
    end
    obs_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_cnt", 32'(bus.err_cnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sync", 32'(bus.err_sync), 32'd0);
    reset = 1'b0;
    repeat (20) cyc();
    send_frame(8'hA5, 1'b0);
    score("good_a5");
    send_frame(8'h01, 1'b0);
    score("perr_01");
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    check("sync_pulse", 32'(sync_cnt), 32'd1);
    check("sync_no_valid", 32'(obs_q.size()), 32'd0);
    model_cnt++;
    expect_frame(8'h3C, 1'b0);
    send_data(8'h3C, 1'b0);
    send_bit(1'b0, 1'b0);
    score("resync_3c");
    check("sync_cnt2", 32'(bus2.err_cnt), 32'd2);
    s_line = 1'b1;
    repeat (4) cyc();
    check("glitch_busy", 32'(bus.busy), 32'd1);
    s_line = 1'b0;
    repeat (30) cyc();
    check("glitch_idle", 32'(bus.busy), 32'd0);
    check("glitch_no_valid", 32'(obs_q.size()), 32'd0);
    check("glitch_no_sync", 32'(sync_cnt), 32'd1);
    check("glitch_cnt", 32'(bus.err_cnt), 32'd2);
    for (int f = 0; f < 5; f++) begin
      send_frame(8'h01, 1'b0);
      score("sat_frame");
    end
    check("sat_cnt2", 32'(bus2.err_cnt), 32'd3);
    check("sat_cnt8", 32'(bus.err_cnt), 32'd7);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    check("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_data", 32'(bus.data_out), 32'd0);
    check("mid_rst_perr", 32'(bus.err_parity), 32'd0);
    check("mid_rst_cnt", 32'(bus.err_cnt), 32'd0);
    check("mid_rst_cnt2", 32'(bus2.err_cnt), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_valid", 32'(bus.valid), 32'd0);
    check("mid_rst_sync", 32'(bus.err_sync), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) send_bit(1'b0, 1'b1);
    check("post_rst_no_valid", 32'(obs_q.size()), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
